// File: rtl/dino_game_ctrl_if.sv
// dino_game_ctrl_if
// Groups the controller's inputs and game outputs into one bundle.
//   master side (VGA timing / button / consumer):
//     drives  pixel_x[9:0], pixel_y[9:0], jump_btn
//     reads   dino_y[9:0], obstacle_x1[9:0], obstacle_x2[9:0], game_over, score[15:0]
//   slave side (dino_game_ctrl): the mirror image.
interface dino_game_ctrl_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        jump_btn;
    logic [9:0]  dino_y;
    logic [9:0]  obstacle_x1;
    logic [9:0]  obstacle_x2;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output pixel_x, pixel_y, jump_btn,
        input  dino_y, obstacle_x1, obstacle_x2, game_over, score
    );

    modport slave (
        input  pixel_x, pixel_y, jump_btn,
        output dino_y, obstacle_x1, obstacle_x2, game_over, score
    );
endinterface

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl
// Frame-rate game-state controller for the Chrome-dino game. Once per frame,
// at the start of vertical blanking, it advances the dino jump physics,
// scrolls two obstacles, checks for a collision and steps the
// IDLE/RUN/OVER state machine.
// Ports:
//   vga_clk  pixel clock, the only clock
//   rst_n    asynchronous active-low reset
//   bus      dino_game_ctrl_if.slave
//              in : pixel_x, pixel_y (VGA counters), jump_btn (raw button)
//              out: dino_y, obstacle_x1, obstacle_x2, game_over, score
module dino_game_ctrl #(
    parameter int DINO_X     = 50,
    parameter int DINO_W     = 50,
    parameter int OBST_W     = 30,
    parameter int OBST_H     = 150,
    parameter int OBST1_INIT = 640,
    parameter int OBST2_INIT = 960,
    parameter int RESPAWN_X  = 700,
    parameter int SPEED      = 4,
    parameter int JUMP_V     = 20,
    parameter int GRAVITY    = 1
) (
    input logic             vga_clk,
    input logic             rst_n,
    dino_game_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    localparam logic [9:0]        JUMP_Y     = 10'(JUMP_V);
    localparam logic signed [7:0] LAUNCH_VEL = 8'(JUMP_V - GRAVITY);
    localparam logic signed [7:0] GRAV       = 8'(GRAVITY);
    localparam logic [9:0]        STEP       = 10'(SPEED);
    localparam logic [9:0]        RESPAWN    = 10'(RESPAWN_X);
    localparam logic [9:0]        X1_INIT    = 10'(OBST1_INIT);
    localparam logic [9:0]        X2_INIT    = 10'(OBST2_INIT);
    localparam logic [9:0]        OBST_TOP   = 10'(OBST_H);
    localparam logic [10:0]       HIT_LEFT   = 11'(DINO_X);
    localparam logic [10:0]       HIT_RIGHT  = 11'(DINO_X + DINO_W - 1);
    localparam logic [10:0]       OBST_SPAN  = 11'(OBST_W - 1);

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              btn_prev;
    logic              jump_pending;
    logic [9:0]        dino_y;
    logic signed [7:0] vel;
    logic [9:0]        obst_x1;
    logic [9:0]        obst_x2;
    logic              game_over;
    logic [15:0]       score;

    logic              tick;
    logic              btn_edge;
    logic              grounded;
    logic signed [10:0] sum;
    logic [9:0]        nxt_y;
    logic signed [7:0] nxt_vel;
    logic [9:0]        nxt_x1;
    logic [9:0]        nxt_x2;
    logic              hit1;
    logic              hit2;
    logic              hit;

    // One-cycle pulse at the first pixel of vertical blanking.
    assign tick     = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd480);
    assign btn_edge = sync2 & ~btn_prev;

    // Candidate values for a RUN tick. The height sum is done at 11-bit
    // signed width so a falling dino can go below zero and be clamped.
    // Collision uses the post-move positions and height of this same tick.
    always_comb begin
        grounded = (dino_y == 10'd0) && (vel == 8'sd0);
        sum      = $signed({1'b0, dino_y} + {{3{vel[7]}}, vel});
        nxt_y    = dino_y;
        nxt_vel  = vel;
        if (grounded) begin
            if (jump_pending) begin
                nxt_y   = JUMP_Y;
                nxt_vel = LAUNCH_VEL;
            end
        end else if (sum <= 11'sd0) begin
            nxt_y   = 10'd0;
            nxt_vel = 8'sd0;
        end else begin
            nxt_y   = sum[9:0];
            nxt_vel = vel - GRAV;
        end

        nxt_x1 = (obst_x1 >= STEP) ? (obst_x1 - STEP) : RESPAWN;
        nxt_x2 = (obst_x2 >= STEP) ? (obst_x2 - STEP) : RESPAWN;

        hit1 = ({1'b0, nxt_x1} <= HIT_RIGHT) && (({1'b0, nxt_x1} + OBST_SPAN) >= HIT_LEFT);
        hit2 = ({1'b0, nxt_x2} <= HIT_RIGHT) && (({1'b0, nxt_x2} + OBST_SPAN) >= HIT_LEFT);
        hit  = (nxt_y < OBST_TOP) && (hit1 || hit2);
    end

    // Button synchronizer, press latch and the game state machine. A press
    // landing on the tick cycle itself survives the clear and is serviced
    // at the following tick.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            btn_prev     <= 1'b0;
            jump_pending <= 1'b0;
            dino_y       <= 10'd0;
            vel          <= 8'sd0;
            obst_x1      <= X1_INIT;
            obst_x2      <= X2_INIT;
            game_over    <= 1'b0;
            score        <= 16'd0;
        end else begin
            sync1    <= bus.jump_btn;
            sync2    <= sync1;
            btn_prev <= sync2;

            if (tick) begin
                jump_pending <= btn_edge;
            end else if (btn_edge) begin
                jump_pending <= 1'b1;
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (jump_pending) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        dino_y  <= nxt_y;
                        vel     <= nxt_vel;
                        obst_x1 <= nxt_x1;
                        obst_x2 <= nxt_x2;
                        if (hit) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else if (score != 16'hFFFF) begin
                            score <= score + 16'd1;
                        end
                    end
                    OVER: begin
                        if (jump_pending) begin
                            state     <= IDLE;
                            dino_y    <= 10'd0;
                            vel       <= 8'sd0;
                            obst_x1   <= X1_INIT;
                            obst_x2   <= X2_INIT;
                            score     <= 16'd0;
                            game_over <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dino_y      = dino_y;
    assign bus.obstacle_x1 = obst_x1;
    assign bus.obstacle_x2 = obst_x2;
    assign bus.game_over   = game_over;
    assign bus.score       = score;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl
// Drives two controllers from the same stimulus: dut_a with default
// parameters and dut_b with OBST_H=0 (collision disabled). Frames are
// shortened to 8 clocks, the last of which is the tick position. A game
// model built from the game rules predicts every output each cycle, and
// hand-computed values pin both the model and the DUTs at key points.
module tb_dino_game_ctrl;

    localparam int DINO_X     = 50;
    localparam int DINO_W     = 50;
    localparam int OBST_W     = 30;
    localparam int OBST_H     = 150;
    localparam int OBST1_INIT = 640;
    localparam int OBST2_INIT = 960;
    localparam int RESPAWN_X  = 700;
    localparam int SPEED      = 4;
    localparam int JUMP_V     = 20;
    localparam int GRAVITY    = 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    typedef struct {
        int mode;
        int y;
        int v;
        int x1;
        int x2;
        int score;
    } game_t;

    logic       vga_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [9:0] px      = 10'd5;
    logic [9:0] py      = 10'd0;
    logic       btn     = 1'b0;
    bit         check_en = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    always #5 vga_clk = ~vga_clk;

    dino_game_ctrl_if bus_a ();
    dino_game_ctrl_if bus_b ();

    assign bus_a.pixel_x  = px;
    assign bus_a.pixel_y  = py;
    assign bus_a.jump_btn = btn;
    assign bus_b.pixel_x  = px;
    assign bus_b.pixel_y  = py;
    assign bus_b.jump_btn = btn;

    dino_game_ctrl dut_a (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus_a.slave)
    );

    dino_game_ctrl #(.OBST_H(0)) dut_b (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus_b.slave)
    );

    // ---------------- game model ----------------
    function automatic game_t game_reset();
        game_t g;
        g.mode  = M_IDLE;
        g.y     = 0;
        g.v     = 0;
        g.x1    = OBST1_INIT;
        g.x2    = OBST2_INIT;
        g.score = 0;
        return g;
    endfunction

    function automatic int move(input int x);
        return (x >= SPEED) ? x - SPEED : RESPAWN_X;
    endfunction

    function automatic bit hits(input int x, input int y, input int obst_h);
        return (x <= DINO_X + DINO_W - 1) && (x + OBST_W - 1 >= DINO_X) && (y < obst_h);
    endfunction

    function automatic game_t step(input game_t g, input bit press, input int obst_h);
        game_t n = g;
        case (g.mode)
            M_IDLE: if (press) n.mode = M_RUN;
            M_RUN: begin
                if (g.y == 0 && g.v == 0) begin
                    if (press) begin
                        n.y = JUMP_V;
                        n.v = JUMP_V - GRAVITY;
                    end
                end else if (g.y + g.v <= 0) begin
                    n.y = 0;
                    n.v = 0;
                end else begin
                    n.y = g.y + g.v;
                    n.v = g.v - GRAVITY;
                end
                n.x1 = move(g.x1);
                n.x2 = move(g.x2);
                if (hits(n.x1, n.y, obst_h) || hits(n.x2, n.y, obst_h))
                    n.mode = M_OVER;
                else if (n.score < 65535)
                    n.score = n.score + 1;
            end
            default: if (press) n = game_reset();
        endcase
        return n;
    endfunction

    game_t    ga;
    game_t    gb;
    bit       m_pend;
    bit [2:0] hist;  // hist[i] = button sampled i+1 clocks ago

    // A button rise is seen by the game three clocks after it is sampled.
    always @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            ga     <= game_reset();
            gb     <= game_reset();
            m_pend <= 1'b0;
            hist   <= 3'b000;
        end else begin
            hist <= {hist[1:0], btn};
            if (px == 10'd0 && py == 10'd480) begin
                ga     <= step(ga, m_pend, OBST_H);
                gb     <= step(gb, m_pend, 0);
                m_pend <= hist[1] & ~hist[2];
            end else if (hist[1] & ~hist[2]) begin
                m_pend <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Every cycle, both DUTs must agree with the model.
    always @(negedge vga_clk) begin
        if (check_en) begin
            checkOutput("a.dino_y",    bus_a.dino_y,      ga.y);
            checkOutput("a.x1",        bus_a.obstacle_x1, ga.x1);
            checkOutput("a.x2",        bus_a.obstacle_x2, ga.x2);
            checkOutput("a.game_over", bus_a.game_over,   ga.mode == M_OVER);
            checkOutput("a.score",     bus_a.score,       ga.score);
            checkOutput("b.dino_y",    bus_b.dino_y,      gb.y);
            checkOutput("b.x1",        bus_b.obstacle_x1, gb.x1);
            checkOutput("b.x2",        bus_b.obstacle_x2, gb.x2);
            checkOutput("b.game_over", bus_b.game_over,   gb.mode == M_OVER);
            checkOutput("b.score",     bus_b.score,       gb.score);
        end
    end

    // Hand-computed values for dut_a, checked against both DUT and model.
    task automatic pinA(input string tag, input int y, input int x1, input int x2,
                        input int go, input int sc);
        checkOutput({tag, " a.dino_y"},    bus_a.dino_y,      y);
        checkOutput({tag, " a.x1"},        bus_a.obstacle_x1, x1);
        checkOutput({tag, " a.x2"},        bus_a.obstacle_x2, x2);
        checkOutput({tag, " a.game_over"}, bus_a.game_over,   go);
        checkOutput({tag, " a.score"},     bus_a.score,       sc);
        checkOutput({tag, " model a.y"},   ga.y,     y);
        checkOutput({tag, " model a.x1"},  ga.x1,    x1);
        checkOutput({tag, " model a.sc"},  ga.score, sc);
    endtask

    task automatic pinB(input string tag, input int y, input int x1, input int x2,
                        input int go, input int sc);
        checkOutput({tag, " b.dino_y"},    bus_b.dino_y,      y);
        checkOutput({tag, " b.x1"},        bus_b.obstacle_x1, x1);
        checkOutput({tag, " b.x2"},        bus_b.obstacle_x2, x2);
        checkOutput({tag, " b.game_over"}, bus_b.game_over,   go);
        checkOutput({tag, " b.score"},     bus_b.score,       sc);
        checkOutput({tag, " model b.x1"},  gb.x1,    x1);
        checkOutput({tag, " model b.x2"},  gb.x2,    x2);
    endtask

    // Runs whole frames of 8 clocks; the tick is the last clock. Clock 3
    // puts pixel_x at 0 on another line, which must not tick. With press
    // set, the button is held for clocks 1-2 of the first frame.
    task automatic applyStimulus(input int frames, input bit press);
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge vga_clk);
                if (c == 7) begin
                    px = 10'd0;
                    py = 10'd480;
                end else if (c == 3) begin
                    px = 10'd0;
                    py = 10'd479;
                end else begin
                    px = 10'(c + 1);
                    py = 10'd480;
                end
                btn = press && (f == 0) && (c == 1 || c == 2);
            end
        end
        @(negedge vga_clk);
        px  = 10'd5;
        py  = 10'd0;
        btn = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge vga_clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        pinA("reset", 0, 640, 960, 0, 0);

        applyStimulus(3, 1'b0);
        pinA("idle3", 0, 640, 960, 0, 0);

        applyStimulus(1, 1'b1);
        pinA("start", 0, 640, 960, 0, 0);

        applyStimulus(135, 1'b0);
        pinA("run135", 0, 100, 420, 0, 135);

        applyStimulus(1, 1'b0);
        pinA("hit", 0, 96, 416, 1, 135);

        applyStimulus(24, 1'b0);
        pinA("frozen", 0, 96, 416, 1, 135);
        pinB("wrap0", 0, 0, 320, 0, 160);

        applyStimulus(1, 1'b0);
        pinB("wrap700", 0, 700, 316, 0, 161);

        applyStimulus(1, 1'b1);
        pinA("restart", 0, 640, 960, 0, 0);

        applyStimulus(1, 1'b1);
        pinA("start2", 0, 640, 960, 0, 0);

        applyStimulus(1, 1'b1);
        pinA("jump1", 20, 636, 956, 0, 1);

        applyStimulus(8, 1'b0);
        applyStimulus(1, 1'b1);
        pinA("jump10", 155, 600, 920, 0, 10);

        applyStimulus(10, 1'b0);
        pinA("jump20", 210, 560, 880, 0, 20);

        applyStimulus(21, 1'b0);
        pinA("jump41", 0, 476, 796, 0, 41);

        applyStimulus(1, 1'b0);
        pinA("grounded", 0, 472, 792, 0, 42);

        applyStimulus(1, 1'b1);
        applyStimulus(9, 1'b0);
        pinA("midjump", 155, 432, 752, 0, 52);

        @(negedge vga_clk);
        #2 rst_n = 1'b0;
        #1;
        pinA("async", 0, 640, 960, 0, 0);
        pinB("async", 0, 640, 960, 0, 0);

        repeat (2) @(negedge vga_clk);
        rst_n = 1'b1;
        applyStimulus(2, 1'b0);
        pinA("postreset", 0, 640, 960, 0, 0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
